re2_copro_axil_slave_regs: RTL

AXI4-Lite slave register file for the re2_copro S00_AXI port; this is the responder side of the master VIP traffic used in the co-processor BFM bench.
- Exposes NUM_REGS 32-bit read/write registers at word offsets 0x0, 0x4, 0x8, 0xC.
- Drives register contents and per-register write strobes to co-processor core logic.
- Single outstanding transaction per direction; independent write and read paths.

---
 rtl/re2_copro_axil_pkg.sv | 29 ++
 rtl/re2_copro_axil_slave_regs.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/re2_copro_axil_pkg.sv
// Shared definitions for the re2_copro S00_AXI slave register file.
// Holds the AXI response codes, FSM state encodings, the register stride
// and a small range-check helper used by the address decoder.
package re2_copro_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte distance between consecutive registers.
    localparam int REG_STRIDE = 4;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_WAIT_DATA = 2'd1,  // AW accepted, waiting for W
        W_WAIT_ADDR = 2'd2,  // W accepted, waiting for AW
        W_RESP      = 2'd3   // write committed, B outstanding
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1        // R outstanding
    } rd_state_t;

    // True when a decoded word index addresses an implemented register.
    function automatic logic idx_in_range(input int unsigned idx, input int unsigned num);
        return idx < num;
    endfunction

endpackage

// File: rtl/re2_copro_axil_slave_regs.sv
// AXI4-Lite slave register file for the re2_copro S00_AXI port.
//
// Implements NUM_REGS 32-bit read/write registers at word offsets 0x0, 0x4,
// 0x8, 0xC. Out-of-range word indices answer SLVERR (writes dropped, reads
// return 0). One transaction may be outstanding per direction; the write and
// read paths are fully independent.
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*       write address / data / response channels
//   S_AXI_AR*/R*          read address / data channels
//   reg_q                 register contents, reg i at [32i+31:32i]
//   reg_wr_pulse          one-cycle pulse per register on each commit
//
// Handshake semantics: a transfer occurs on a rising ACLK edge where both
// VALID and READY are high. Once this block raises BVALID or RVALID it holds
// the payload (BRESP, or RDATA/RRESP) stable until the matching READY is seen.
// The block's READY outputs never depend combinationally on the master's
// VALID inputs; they are decoded from the registered FSM state only.
module re2_copro_axil_slave_regs
    import re2_copro_axil_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]          reg_q,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

    // Half of a write that arrived before its partner channel.
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]             w_strb_q;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // READY is forced low while reset is held so the master sees no acceptance.
    assign S_AXI_AWREADY = !ARESET && (wr_state == W_IDLE || wr_state == W_WAIT_ADDR);
    assign S_AXI_WREADY  = !ARESET && (wr_state == W_IDLE || wr_state == W_WAIT_DATA);
    assign S_AXI_ARREADY = !ARESET && (rd_state == R_IDLE);

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // ------------------------------------------------------------------
    // Commit selection: the write completes on the edge where the last of
    // the two channel handshakes happens, taking each half either from the
    // bus or from the capture registers.
    // ------------------------------------------------------------------
    logic                          commit_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0] commit_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]             commit_strb;
    logic [IDX_W-1:0]              commit_idx;
    logic                          commit_ok;

    always_comb begin
        commit_en   = 1'b0;
        commit_addr = S_AXI_AWADDR;
        commit_data = S_AXI_WDATA;
        commit_strb = S_AXI_WSTRB;
        case (wr_state)
            W_IDLE:      commit_en = aw_hs && w_hs;
            W_WAIT_DATA: begin
                commit_en   = w_hs;
                commit_addr = aw_addr_q;
            end
            W_WAIT_ADDR: begin
                commit_en   = aw_hs;
                commit_data = w_data_q;
                commit_strb = w_strb_q;
            end
            default:     commit_en = 1'b0;
        endcase
    end

    assign commit_idx = commit_addr[C_S_AXI_ADDR_WIDTH-1:2];
    assign commit_ok  = idx_in_range(32'(commit_idx), NUM_REGS);

    // ------------------------------------------------------------------
    // Write FSM, register array and write strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state     <= W_IDLE;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            reg_wr_pulse <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            reg_wr_pulse <= '0;

            case (wr_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state <= W_RESP;
                    end else if (aw_hs) begin
                        aw_addr_q <= S_AXI_AWADDR;
                        wr_state  <= W_WAIT_DATA;
                    end else if (w_hs) begin
                        w_data_q <= S_AXI_WDATA;
                        w_strb_q <= S_AXI_WSTRB;
                        wr_state <= W_WAIT_ADDR;
                    end
                end
                W_WAIT_DATA: if (w_hs)  wr_state <= W_RESP;
                W_WAIT_ADDR: if (aw_hs) wr_state <= W_RESP;
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        wr_state     <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase

            if (commit_en) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= commit_ok ? RESP_OKAY : RESP_SLVERR;
            end

            // Byte-merged update; out-of-range indices match no register.
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (commit_en && commit_ok && commit_idx == IDX_W'(i)) begin
                    reg_wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (commit_strb[b]) begin
                            regs[i][8*b +: 8] <= commit_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: mux the addressed register (0 when out of range) and
    // capture it on the AR handshake. Reading the flops directly means a
    // read on the same edge as a commit returns the pre-write value.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]              rd_idx;
    logic                          rd_ok;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

    assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_ok  = idx_in_range(32'(rd_idx), NUM_REGS);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state     <= R_IDLE;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RDATA  <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        S_AXI_RDATA  <= rd_word;
                        S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        S_AXI_RVALID <= 1'b1;
                        rd_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        rd_state     <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < int'(NUM_REGS); gi++) begin : g_reg_q
            assign reg_q[32*gi +: 32] = regs[gi];
        end
    endgenerate

endmodule
